// File: rtl/neural_network_dotctl_pkg.sv
// Shared definitions for the neural_network_dotctl dot-product controller.
// Holds the FSM state encoding, the multiplier pipeline depth and the default
// operand / length / accumulator widths used by the interface and the RTL.
package neural_network_dotctl_pkg;

  localparam int DEF_A_W   = 11;
  localparam int DEF_B_W   = 11;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 32;

  // Cycles from an accepted operand pair to its product being available.
  localparam int MUL_LAT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The multiplier pipeline advances only while operands can be in flight.
  function automatic logic mul_ce(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/neural_network_dotctl_if.sv
// Job / operand / result bus of neural_network_dotctl.
//   start, len      : job start pulse and number of products (sampled on start)
//   busy            : job in progress until the result handshake
//   in_valid/ready  : operand stream handshake, in_a / in_b operand pair
//   out_valid/ready : result handshake, out_sum the dot product
//   bias            : accumulator preload, present only with
//                     NEURAL_NETWORK_DOTCTL_BIAS_EN defined
// master = job issuer, slave = the controller.
interface neural_network_dotctl_if #(
  parameter int A_W   = neural_network_dotctl_pkg::DEF_A_W,
  parameter int B_W   = neural_network_dotctl_pkg::DEF_B_W,
  parameter int LEN_W = neural_network_dotctl_pkg::DEF_LEN_W,
  parameter int ACC_W = neural_network_dotctl_pkg::DEF_ACC_W
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
`ifdef NEURAL_NETWORK_DOTCTL_BIAS_EN
  logic [ACC_W-1:0] bias;
`endif

  modport master (
`ifdef NEURAL_NETWORK_DOTCTL_BIAS_EN
    output bias,
`endif
    output start, len, in_valid, in_a, in_b, out_ready,
    input  busy, in_ready, out_valid, out_sum
  );

  modport slave (
`ifdef NEURAL_NETWORK_DOTCTL_BIAS_EN
    input  bias,
`endif
    input  start, len, in_valid, in_a, in_b, out_ready,
    output busy, in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/neural_network_dotctl_mul.sv
// Unsigned two-stage multiplier: registered operands, registered product.
//   clk : clock
//   ce  : advance both pipeline stages
//   a,b : unsigned operands
//   p   : a*b from two enabled edges earlier
// No reset: validity of the pipeline contents is tracked by the caller.
module neural_network_dotctl_mul #(
  parameter int A_W = neural_network_dotctl_pkg::DEF_A_W,
  parameter int B_W = neural_network_dotctl_pkg::DEF_B_W
) (
  input  logic               clk,
  input  logic               ce,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] p_q;

  // Operand capture stage followed by the product stage.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= a;
      b_q <= b;
      p_q <= P_W'(a_q) * P_W'(b_q);
    end
  end

  assign p = p_q;

endmodule

// File: rtl/neural_network_dotctl.sv
// Dot-product job controller.
//   clk   : single clock, rising edge
//   reset : synchronous, active low
//   bus   : neural_network_dotctl_if.slave (job, operand and result streams)
// A start in IDLE loads len and clears (or biases) the accumulator; operand
// pairs are multiplied in a two-stage pipeline and summed exactly; the sum is
// presented in DONE until out_ready. Optional macro
// NEURAL_NETWORK_DOTCTL_BIAS_EN preloads the accumulator from bus.bias.
module neural_network_dotctl
  import neural_network_dotctl_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic clk,
  input  logic reset,
  neural_network_dotctl_if.slave bus
);

  localparam int P_W = A_W + B_W;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [MUL_LAT-1:0] vld_q, vld_d;
  logic               busy_q, in_ready_q, out_valid_q;
  logic [ACC_W-1:0]   init_s;
  logic               accept_s;
  logic               ce_s;
  logic [P_W-1:0]     prod_s;

`ifdef NEURAL_NETWORK_DOTCTL_BIAS_EN
  assign init_s = bus.bias;
`else
  assign init_s = '0;
`endif

  assign ce_s     = mul_ce(state_q);
  assign accept_s = in_ready_q & bus.in_valid;

  neural_network_dotctl_mul #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_mul (
    .clk(clk),
    .ce (ce_s),
    .a  (bus.in_a),
    .b  (bus.in_b),
    .p  (prod_s)
  );

  // Next-state, count, accumulator and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    // Each accepted pair enters the valid pipe; idle cycles enter as bubbles.
    vld_d   = {vld_q[MUL_LAT-2:0], accept_s};
    if (vld_q[MUL_LAT-1]) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d = bus.len;
          acc_d = init_s;
          if (bus.len == '0) begin
            state_d = ST_DONE;
            sum_d   = init_s;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          cnt_d = cnt_q - LEN_W'(1'b1);
          if (cnt_q == LEN_W'(1'b1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Pipe empty here means the final add landed on the previous edge.
        if (vld_q == '0) begin
          state_d = ST_DONE;
          sum_d   = acc_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      vld_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      vld_q       <= vld_d;
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_RUN) && (cnt_d != '0);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;

endmodule
